// File: rtl/conv_out_requant_pkg.sv
// conv_out_requant shared definitions.
// Types, states and sizing constants for the requant stage.
package conv_out_requant_pkg;

  localparam int K_CHANNELS  = 6;
  localparam int ACC_WIDTH   = 32;
  localparam int INT_WIDTH   = 8;
  localparam int SRAM_ADDR_W = 12;
  localparam int RQ_DIM_W    = 11;
  localparam int RQ_PIPE_LAT = 3;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef logic signed [INT_WIDTH-1:0] qout_t;

  typedef enum logic [1:0] {
    RQ_IDLE,
    RQ_RUN,
    RQ_DRAIN,
    RQ_DONE
  } requant_state_e;

endpackage

// File: rtl/conv_out_requant_pipe.sv
// requant_pipe: bias add, ReLU, shift, saturate in 3 stages.
// REQUANT_ROUND_EN selects round-half-up before the shift.
module requant_pipe #(
  parameter int ACC_W  = 32,
  parameter int OUT_DW = 8,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     in_valid,
  input  logic signed [ACC_W-1:0]  in_acc,
  input  logic signed [ACC_W-1:0]  in_bias,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [4:0]               shift,
  output logic                     out_we,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [OUT_DW-1:0]        out_data,
  output logic                     empty
);

  localparam int MAXV = 2 ** (OUT_DW - 1) - 1;

  logic                    s1_v;
  logic                    s2_v;
  logic signed [ACC_W:0]   s1_sum;
  logic [ADDR_W-1:0]       s1_addr;
  logic [ADDR_W-1:0]       s2_addr;
  logic [ACC_W+1:0]        s2_val;
  logic [ACC_W+1:0]        relu;
  logic [ACC_W+1:0]        rnd;
  logic [ACC_W+1:0]        shifted;
  logic [OUT_DW-1:0]       sat;

  always_comb begin
    relu = s1_sum[ACC_W] ? '0 : {1'b0, s1_sum};
    rnd  = '0;
`ifdef REQUANT_ROUND_EN
    if (shift != 5'd0) rnd = (ACC_W+2)'(1) << (shift - 5'd1);
`endif
    shifted = (relu + rnd) >> shift;
    sat = (s2_val > (ACC_W+2)'(MAXV)) ? OUT_DW'(MAXV)
                                       : s2_val[OUT_DW-1:0];
  end

  // A stall freezes every stage so no element is lost or duplicated.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_sum   <= '0;
      s1_addr  <= '0;
      s2_v     <= 1'b0;
      s2_val   <= '0;
      s2_addr  <= '0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else if (!stall) begin
      s1_v     <= in_valid;
      s1_sum   <= {in_acc[ACC_W-1], in_acc} + {in_bias[ACC_W-1], in_bias};
      s1_addr  <= in_addr;
      s2_v     <= s1_v;
      s2_val   <= shifted;
      s2_addr  <= s1_addr;
      out_we   <= s2_v;
      out_addr <= s2_addr;
      out_data <= sat;
    end
  end

  assign empty = !s1_v && !s2_v && !out_we;

endmodule

// File: rtl/conv_out_requant.sv
// conv_out_requant: control FSM, counters and bias file.
// Build with REQUANT_ROUND_EN for rounding requantisation.
module conv_out_requant
  import conv_out_requant_pkg::*;
#(
  parameter int N_CH   = K_CHANNELS,
  parameter int ACC_W  = ACC_WIDTH,
  parameter int OUT_DW = INT_WIDTH,
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DIM_W  = RQ_DIM_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DIM_W-1:0]            cfg_out_w,
  input  logic [DIM_W-1:0]            cfg_out_h,
  input  logic [4:0]                  cfg_shift,
  input  logic [ADDR_W-1:0]           cfg_base_addr,
  input  logic                        bias_we,
  input  logic [$clog2(N_CH)-1:0]     bias_idx,
  input  logic signed [ACC_W-1:0]     bias_data,
  input  logic                        acc_valid,
  input  logic signed [ACC_W-1:0]     acc_data,
  output logic                        acc_ready,
  output logic                        sram_we,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [OUT_DW-1:0]           sram_wdata,
  input  logic                        sram_gnt,
  output logic                        busy,
  output logic                        done
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int PIX_W = 2 * DIM_W;
  localparam int CNT_W = PIX_W + CH_W;

  requant_state_e state, nstate;

  logic signed [ACC_W-1:0] bias_q [N_CH];
  logic [PIX_W-1:0]  pix_tot;
  logic [PIX_W-1:0]  pix;
  logic [CNT_W-1:0]  total;
  logic [CNT_W-1:0]  cnt;
  logic [CH_W-1:0]   ch;
  logic [ADDR_W-1:0] addr;
  logic [4:0]        shift_q;
  logic              stall;
  logic              accept;
  logic              pipe_empty;

  assign stall     = sram_we && !sram_gnt;
  assign acc_ready = (state == RQ_RUN) && !stall;
  assign accept    = acc_valid && acc_ready;
  assign busy      = (state == RQ_RUN) || (state == RQ_DRAIN);
  assign done      = (state == RQ_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= RQ_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      RQ_IDLE:  if (start) nstate = RQ_RUN;
      RQ_RUN:   if (accept && cnt == total - 1'b1) nstate = RQ_DRAIN;
      RQ_DRAIN: if (pipe_empty) nstate = RQ_DONE;
      RQ_DONE:  nstate = RQ_IDLE;
      default:  nstate = RQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) bias_q[i] <= '0;
      pix_tot <= '0;
      pix     <= '0;
      total   <= '0;
      cnt     <= '0;
      ch      <= '0;
      addr    <= '0;
      shift_q <= '0;
    end else begin
      if (bias_we && 32'(bias_idx) < N_CH) bias_q[bias_idx] <= bias_data;
      if (state == RQ_IDLE && start) begin
        pix_tot <= PIX_W'(cfg_out_w) * PIX_W'(cfg_out_h);
        total   <= CNT_W'(N_CH) * CNT_W'(cfg_out_w) * CNT_W'(cfg_out_h);
        shift_q <= cfg_shift;
        addr    <= cfg_base_addr;
        cnt     <= '0;
        pix     <= '0;
        ch      <= '0;
      end else if (accept) begin
        cnt  <= cnt + 1'b1;
        addr <= addr + 1'b1;
        // Channel-major order: channel advances once per full plane.
        if (pix == pix_tot - 1'b1) begin
          pix <= '0;
          ch  <= ch + 1'b1;
        end else begin
          pix <= pix + 1'b1;
        end
      end
    end
  end

  requant_pipe #(
    .ACC_W  (ACC_W),
    .OUT_DW (OUT_DW),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .in_valid (accept),
    .in_acc   (acc_data),
    .in_bias  (bias_q[ch]),
    .in_addr  (addr),
    .shift    (shift_q),
    .out_we   (sram_we),
    .out_addr (sram_addr),
    .out_data (sram_wdata),
    .empty    (pipe_empty)
  );

endmodule

// File: tb/tb_conv_out_requant.sv
// Randomised bench for conv_out_requant with a behavioural model.
// Build with REQUANT_ROUND_EN to check the rounding variant.
module tb_conv_out_requant;
  import conv_out_requant_pkg::*;

  logic         clk;
  logic         rst;
  logic         start;
  logic [10:0]  cfg_out_w;
  logic [10:0]  cfg_out_h;
  logic [4:0]   cfg_shift;
  logic [11:0]  cfg_base_addr;
  logic         bias_we;
  logic [2:0]   bias_idx;
  acc_t         bias_data;
  logic         acc_valid;
  acc_t         acc_data;
  logic         acc_ready;
  logic         sram_we;
  logic [11:0]  sram_addr;
  logic [7:0]   sram_wdata;
  logic         sram_gnt;
  logic         busy;
  logic         done;

  conv_out_requant dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_out_w     (cfg_out_w),
    .cfg_out_h     (cfg_out_h),
    .cfg_shift     (cfg_shift),
    .cfg_base_addr (cfg_base_addr),
    .bias_we       (bias_we),
    .bias_idx      (bias_idx),
    .bias_data     (bias_data),
    .acc_valid     (acc_valid),
    .acc_data      (acc_data),
    .acc_ready     (acc_ready),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_gnt      (sram_gnt),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
    int stl;
  } exp_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  exp_t   q[$];
  wr_t    wlog[$];
  acc_t   stim[$];
  longint bias_m [6];
  int     total_n = 0;
  int     bad_n   = 0;
  int     cyc     = 0;
  int     stalls  = 0;
  int     done_cnt = 0;
  int     hold    = 0;
  bit     rnd_gnt = 0;
  int     m_w, m_h, m_shift, m_base, m_idx;
  exp_t   e_c;
  int     ch_c;

  task automatic chk(input string name, input longint act, input longint exp);
    total_n++;
    if (act != exp) begin
      bad_n++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Requant rule straight from arithmetic: add, clamp, shift, clamp.
  function automatic int ref_q(input longint a, input longint b, input int sh);
    longint s;
    s = a + b;
    if (s < 0) s = 0;
`ifdef REQUANT_ROUND_EN
    if (sh > 0) s = s + (longint'(1) << (sh - 1));
`endif
    s = s >>> sh;
    if (s > 127) s = 127;
    return int'(s);
  endfunction

  always @(negedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      if (sram_we && !sram_gnt) begin
        chk("stall_ready", acc_ready, 0);
        stalls++;
      end
      if (sram_we && sram_gnt) begin
        total_n++;
        if (q.size() == 0) begin
          bad_n++;
          $display("FAIL spurious_write addr=%0h data=%0d", sram_addr, sram_wdata);
        end else begin
          e_c = q.pop_front();
          chk("wr_addr", sram_addr, e_c.addr);
          chk("wr_data", sram_wdata, e_c.data);
          chk("wr_latency", cyc - e_c.cyc - (stalls - e_c.stl), RQ_PIPE_LAT);
          wlog.push_back('{sram_addr, sram_wdata});
        end
      end
      if (acc_valid && acc_ready) begin
        ch_c = m_idx / (m_w * m_h);
        q.push_back('{(m_base + m_idx) % 4096,
                      ref_q(longint'(acc_data), bias_m[ch_c], m_shift),
                      cyc, stalls});
        m_idx++;
      end
      if (done) begin
        done_cnt++;
        chk("done_queue_empty", q.size(), 0);
        chk("done_count", m_idx, 6 * m_w * m_h);
        chk("done_busy", busy, 0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (hold > 0) begin
      sram_gnt = 1'b0;
      hold--;
    end else if (rnd_gnt) begin
      sram_gnt = ($urandom_range(3) != 0);
    end else begin
      sram_gnt = 1'b1;
    end
  endtask

  task automatic set_bias(input int i, input longint v);
    step();
    bias_we   = 1'b1;
    bias_idx  = 3'(i);
    bias_data = acc_t'(v);
    step();
    bias_we   = 1'b0;
    bias_m[i] = longint'(acc_t'(v));
  endtask

  task automatic run_job(input int w, input int h, input int sh,
                         input int base, input int n, input bit rv,
                         input int hold_at, input int rst_at);
    int idx, guard, d0, lim;
    m_w = w; m_h = h; m_shift = sh; m_base = base; m_idx = 0;
    wlog.delete();
    step();
    start = 1'b1;
    cfg_out_w = 11'(w);
    cfg_out_h = 11'(h);
    cfg_shift = 5'(sh);
    cfg_base_addr = 12'(base);
    step();
    start = 1'b0;
    idx = 0; guard = 0; d0 = done_cnt;
    lim = (rst_at >= 0) ? rst_at : n;
    while (idx < lim && guard < 3000) begin
      if (idx == hold_at) begin
        hold = 5;
        hold_at = -1;
      end
      step();
      guard++;
      acc_valid = rv ? ($urandom_range(2) != 0) : 1'b1;
      acc_data = stim[idx];
      // A start in the middle of a run must be ignored.
      start = (idx == n / 2);
      if (start) cfg_base_addr = 12'($urandom);
      #2;
      if (acc_valid && acc_ready) idx++;
    end
    if (guard >= 3000) chk("accept_timeout", idx, lim);
    step();
    acc_valid = 1'b0;
    start = 1'b0;
    if (rst_at >= 0) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) bias_m[i] = 0;
      #2;
      chk("rst_sram_we", sram_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", acc_ready, 0);
      repeat (15) step();
      chk("rst_no_done", done_cnt, d0);
    end else begin
      guard = 0;
      while (done_cnt == d0 && guard < 40) begin
        step();
        #2;
        guard++;
      end
      chk("done_seen", done_cnt, d0 + 1);
      step();
      #2;
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    int sh, w, h;
    rst = 1'b1; start = 1'b0; bias_we = 1'b0; bias_idx = '0;
    bias_data = '0; acc_valid = 1'b0; acc_data = '0; sram_gnt = 1'b1;
    cfg_out_w = 11'd1; cfg_out_h = 11'd1; cfg_shift = '0;
    cfg_base_addr = '0;
    m_w = 1; m_h = 1; m_shift = 0; m_base = 0; m_idx = 0;
    for (int i = 0; i < 6; i++) bias_m[i] = 0;
    repeat (3) step();
    #2;
    chk("reset_ready", acc_ready, 0);
    chk("reset_we", sram_we, 0);
    chk("reset_addr", sram_addr, 0);
    chk("reset_wdata", sram_wdata, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) set_bias(i, i);
    stim.delete();
    for (int i = 0; i < 24; i++) stim.push_back(acc_t'(i));
    run_job(2, 2, 0, 'h100, 24, 1'b0, -1, -1);
    chk("basic_count", wlog.size(), 24);
    chk("basic_addr0", wlog[0].addr, 'h100);
    chk("basic_data5", wlog[5].data, 6);
    chk("basic_addr23", wlog[23].addr, 'h117);
    chk("basic_data23", wlog[23].data, 28);

    for (int i = 0; i < 6; i++) set_bias(i, 0);
    stim.delete();
    stim.push_back(-5);
    stim.push_back(127);
    stim.push_back(128);
    stim.push_back(32'h7FFF_FFFF);
    stim.push_back(0);
    stim.push_back(0);
    run_job(1, 1, 0, 0, 6, 1'b0, -1, -1);
    chk("relu_neg", wlog[0].data, 0);
    chk("sat_127", wlog[1].data, 127);
    chk("sat_128", wlog[2].data, 127);
    chk("sat_max", wlog[3].data, 127);

    stim.delete();
    stim.push_back(56);
    stim.push_back(55);
    stim.push_back(-100);
    stim.push_back(16);
    stim.push_back(15);
    stim.push_back(31);
    run_job(1, 1, 4, 'h20, 6, 1'b0, -1, -1);
`ifdef REQUANT_ROUND_EN
    chk("shift_56", wlog[0].data, 4);
`else
    chk("shift_56", wlog[0].data, 3);
`endif
    chk("shift_55", wlog[1].data, 3);

    run_job(1, 1, 0, 'hFFE, 6, 1'b0, -1, -1);
    chk("wrap_a0", wlog[0].addr, 'hFFE);
    chk("wrap_a1", wlog[1].addr, 'hFFF);
    chk("wrap_a2", wlog[2].addr, 'h000);
    chk("wrap_a3", wlog[3].addr, 'h001);

    for (int i = 0; i < 6; i++) set_bias(i, i);
    stim.delete();
    for (int i = 0; i < 24; i++) stim.push_back(acc_t'(i));
    run_job(2, 2, 0, 'h100, 24, 1'b0, 10, -1);
    chk("bp_count", wlog.size(), 24);
    for (int k = 0; k < wlog.size(); k++) begin
      chk("bp_addr", wlog[k].addr, 'h100 + k);
      chk("bp_data", wlog[k].data, k + k / 4);
    end

    run_job(2, 2, 0, 'h100, 24, 1'b0, -1, 7);
    for (int i = 0; i < 6; i++) set_bias(i, 10 * i);
    run_job(2, 2, 0, 'h100, 24, 1'b0, -1, -1);
    chk("post_rst_count", wlog.size(), 24);
    chk("post_rst_data23", wlog[23].data, 73);

    rnd_gnt = 1'b1;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 6; i++)
        set_bias(i, $urandom_range(1) ? longint'($urandom_range(400)) - 200
                                      : longint'($urandom));
      w  = $urandom_range(3, 1);
      h  = $urandom_range(3, 1);
      sh = $urandom_range(1) ? $urandom_range(31) : $urandom_range(6);
      stim.delete();
      for (int i = 0; i < 6 * w * h; i++)
        stim.push_back($urandom_range(1) ? acc_t'(int'($urandom_range(600)) - 300)
                                         : acc_t'($urandom));
      run_job(w, h, sh, int'($urandom_range(4095)), 6 * w * h, 1'b1, -1, -1);
      chk("rand_count", wlog.size(), 6 * w * h);
    end

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
